// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses the instruction ROM and
// loads the IF/ID register, honouring redirect, stall and halt in that order.
module instruction_fetch #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  INST_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 1,
  parameter logic [4:0]          HALT_OP    = 5'b11010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic [PC_WIDTH-1:0]   pc_out,
  input  logic [INST_WIDTH-1:0] instruction_in,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t                  state, state_next;
  logic [PC_WIDTH-1:0]     pc, pc_next;
  logic                    valid_next;
  logic [INST_WIDTH-1:0]   inst_next;
  logic [PC_WIDTH-1:0]     ipc_next;
  logic [15:0]             count_next;
  logic                    is_halt;

  assign is_halt = (instruction_in[INST_WIDTH-1:INST_WIDTH-5] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= '0;
      if_pc       <= '0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_valid    <= valid_next;
      if_inst     <= inst_next;
      if_pc       <= ipc_next;
      fetch_count <= count_next;
    end
  end

  // Redirect beats stall, and stall beats the halted bubble stream.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = if_valid;
    inst_next  = if_inst;
    ipc_next   = if_pc;
    count_next = fetch_count;
    if (redirect_valid) begin
      pc_next    = redirect_target;
      valid_next = 1'b0;
      state_next = FETCH;
    end else if (stall) begin
      state_next = state;
    end else if (state == HALTED) begin
      valid_next = 1'b0;
    end else begin
      inst_next  = instruction_in;
      ipc_next   = pc;
      valid_next = 1'b1;
      if (fetch_count != 16'hFFFF) count_next = fetch_count + 16'd1;
      // A halt parks the PC on itself so it is delivered only once.
      if (is_halt) state_next = HALTED;
      else         pc_next    = pc + PC_WIDTH'(1);
    end
  end

  assign pc_out = pc;
  assign halted = (state == HALTED);

endmodule
